// File: rtl/booth24_mult.sv
// Sequential Q2.22 signed multiplier, radix-4 Booth, one digit per clock.
// Product is floored to Q2.22 and saturated; start/busy/done handshake.
module booth24_mult (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [23:0] a,
  input  logic [23:0] b,
  output logic [23:0] s,
  output logic        busy,
  output logic        done
);

  localparam int unsigned W     = 24;
  localparam int unsigned AW    = 48;
  localparam int unsigned CW    = 4;
  localparam int unsigned FRAC  = 22;
  localparam int unsigned STEPS = 12;

  typedef enum logic [1:0] {IDLE, CALC, FINISH} state_t;

  state_t          state, state_n;
  logic [AW-1:0]   mcand, mcand_n;
  logic [W-1:0]    mplier, mplier_n;
  logic            prev, prev_n;
  logic [AW-1:0]   acc, acc_n;
  logic [CW-1:0]   cnt, cnt_n;
  logic [W-1:0]    s_n;
  logic            busy_n, done_n;

  logic [2:0]        trip;
  logic [AW-1:0]     addend;
  logic signed [AW-1:0] r;
  logic [W-1:0]      s_sat;

  // Booth digit select; the multiplicand is pre-shifted by 2i, the multiplier consumed 2 bits/step
  always_comb begin
    trip = {mplier[1], mplier[0], prev};
    case (trip)
      3'b001, 3'b010: addend = mcand;
      3'b011:         addend = mcand << 1;
      3'b100:         addend = -(mcand << 1);
      3'b101, 3'b110: addend = -mcand;
      default:        addend = '0;
    endcase
  end

  // Floor to Q2.22 by arithmetic shift, then clamp to the 24-bit signed range
  always_comb begin
    r = $signed(acc) >>> FRAC;
    if (r > 48'sh0000_007F_FFFF)
      s_sat = 24'h7F_FFFF;
    else if (r < 48'shFFFF_FF80_0000)
      s_sat = 24'h80_0000;
    else
      s_sat = r[W-1:0];
  end

  always_comb begin
    state_n  = state;
    mcand_n  = mcand;
    mplier_n = mplier;
    prev_n   = prev;
    acc_n    = acc;
    cnt_n    = cnt;
    s_n      = s;
    busy_n   = 1'b0;
    done_n   = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          mcand_n  = {{(AW-W){a[W-1]}}, a};
          mplier_n = b;
          prev_n   = 1'b0;
          acc_n    = '0;
          cnt_n    = '0;
          busy_n   = 1'b1;
          state_n  = CALC;
        end
      end
      CALC: begin
        busy_n   = 1'b1;
        acc_n    = acc + addend;
        mcand_n  = mcand << 2;
        mplier_n = {2'b00, mplier[W-1:2]};
        prev_n   = mplier[1];
        cnt_n    = CW'(cnt + 1'b1);
        if (cnt == CW'(STEPS - 1))
          state_n = FINISH;
      end
      FINISH: begin
        busy_n  = 1'b1;
        done_n  = 1'b1;
        s_n     = s_sat;
        state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      mcand  <= '0;
      mplier <= '0;
      prev   <= 1'b0;
      acc    <= '0;
      cnt    <= '0;
      s      <= '0;
      busy   <= 1'b0;
      done   <= 1'b0;
    end else begin
      state  <= state_n;
      mcand  <= mcand_n;
      mplier <= mplier_n;
      prev   <= prev_n;
      acc    <= acc_n;
      cnt    <= cnt_n;
      s      <= s_n;
      busy   <= busy_n;
      done   <= done_n;
    end
  end

endmodule

// File: tb/tb_booth24_mult.sv
// Self-checking bench for booth24_mult against a floor/saturate arithmetic model.
module tb_booth24_mult;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start = 1'b0;
  logic [23:0] a = '0;
  logic [23:0] b = '0;
  logic [23:0] s;
  logic        busy;
  logic        done;

  int checks = 0;
  int errors = 0;

  booth24_mult dut (
    .clk(clk), .rst(rst), .start(start), .a(a), .b(b),
    .s(s), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  function automatic logic [23:0] model(input logic [23:0] x, input logic [23:0] y);
    longint px, py, p, q;
    px = longint'($signed(x));
    py = longint'($signed(y));
    p  = px * py;
    q  = p >>> 22;
    if (q > 64'sd8388607)       return 24'h7FFFFF;
    else if (q < -64'sd8388608) return 24'h800000;
    else                        return q[23:0];
  endfunction

  // Capture one operation, then wait for done; lat = edges after capture edge
  task automatic run_op(input logic [23:0] xa, input logic [23:0] xb,
                        output logic [23:0] res, output int lat);
    @(negedge clk);
    a = xa; b = xb; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    lat = -1;
    for (int n = 1; n <= 40; n++) begin
      @(posedge clk); #1;
      if (done) begin lat = n; break; end
    end
    res = s;
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst = 1'b1; start = 1'b1; a = 24'h123456; b = 24'h654321;
    repeat (2) @(posedge clk);
    #1;
    checks++; if (s !== 24'h0) begin errors++; $display("FAIL reset_s got %h want 000000", s); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", busy); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done got %b want 0", done); end
    @(negedge clk);
    rst = 1'b0; start = 1'b0;
  endtask

  task automatic test_vectors();
    logic [23:0] va [10] = '{24'h25AD42, 24'hC00000, 24'h800000, 24'hC00000, 24'h4E4C2F,
                             24'h800000, 24'h7FFFFF, 24'h000001, 24'hFFFFFF, 24'h000000};
    logic [23:0] vb [10] = '{24'h2E7525, 24'h200000, 24'h400000, 24'hC00000, 24'h788B43,
                             24'h800000, 24'h800000, 24'h000001, 24'h000001, 24'h7FFFFF};
    logic [23:0] ve [10] = '{24'h1B597D, 24'hE00000, 24'h800000, 24'h400000, 24'h7FFFFF,
                             24'h7FFFFF, 24'h800000, 24'h000000, 24'hFFFFFF, 24'h000000};
    logic [23:0] res;
    int lat;
    for (int i = 0; i < 10; i++) begin
      run_op(va[i], vb[i], res, lat);
      checks++;
      if (lat != 13) begin errors++; $display("FAIL vec%0d_latency got %0d want 13", i, lat); end
      checks++;
      if (res !== ve[i]) begin errors++; $display("FAIL vec%0d_result got %h want %h", i, res, ve[i]); end
      checks++;
      if (busy !== 1'b1) begin errors++; $display("FAIL vec%0d_busy_in_done got %b want 1", i, busy); end
      @(posedge clk); #1;
      checks++;
      if (done !== 1'b0 || busy !== 1'b0) begin
        errors++; $display("FAIL vec%0d_after_done got done=%b busy=%b want 0 0", i, done, busy);
      end
      checks++;
      if (s !== ve[i]) begin errors++; $display("FAIL vec%0d_s_hold got %h want %h", i, s, ve[i]); end
    end
  endtask

  task automatic test_midop_reset();
    int seen;
    logic [23:0] res;
    int lat;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    a = 24'h25AD42; b = 24'h2E7525; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (5) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    seen = 0;
    for (int n = 0; n < 20; n++) begin
      @(negedge clk);
      if (done) seen++;
    end
    checks++; if (seen != 0) begin errors++; $display("FAIL abort_no_done got %0d pulses want 0", seen); end
    checks++; if (s !== 24'h0) begin errors++; $display("FAIL abort_s got %h want 000000", s); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL abort_busy got %b want 0", busy); end
    run_op(24'hC00000, 24'h200000, res, lat);
    checks++;
    if (lat != 13 || res !== 24'hE00000) begin
      errors++; $display("FAIL abort_recover got lat=%0d s=%h want lat=13 s=e00000", lat, res);
    end
  endtask

  task automatic test_ignore_start();
    logic [23:0] a1, b1, exp;
    int lat;
    a1 = 24'($urandom); b1 = 24'($urandom);
    exp = model(a1, b1);
    @(negedge clk);
    a = a1; b = b1; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    lat = -1;
    for (int n = 1; n <= 40; n++) begin
      if (n >= 3 && n <= 9) begin
        start = 1'b1; a = 24'($urandom); b = 24'($urandom);
      end else begin
        start = 1'b0;
      end
      @(posedge clk); #1;
      if (done) begin lat = n; break; end
    end
    start = 1'b0;
    checks++;
    if (lat != 13 || s !== exp) begin
      errors++; $display("FAIL ignore_start got lat=%0d s=%h want lat=13 s=%h", lat, s, exp);
    end
    repeat (2) @(posedge clk);
    #1;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL ignore_start_idle got busy=%b want 0", busy); end
  endtask

  task automatic test_back_to_back();
    logic [23:0] qa [5];
    logic [23:0] qb [5];
    int gap;
    for (int i = 0; i < 5; i++) begin qa[i] = 24'($urandom); qb[i] = 24'($urandom); end
    @(negedge clk);
    a = qa[0]; b = qb[0]; start = 1'b1;
    @(posedge clk); #1;
    for (int j = 0; j < 5; j++) begin
      gap = -1;
      for (int n = 1; n <= 40; n++) begin
        @(posedge clk); #1;
        if (done) begin gap = n; break; end
      end
      if (j < 4) begin a = qa[j+1]; b = qb[j+1]; end
      else start = 1'b0;
      checks++;
      if (gap != ((j == 0) ? 13 : 14)) begin
        errors++; $display("FAIL b2b%0d_interval got %0d want %0d", j, gap, (j == 0) ? 13 : 14);
      end
      checks++;
      if (s !== model(qa[j], qb[j])) begin
        errors++; $display("FAIL b2b%0d_result got %h want %h", j, s, model(qa[j], qb[j]));
      end
    end
    repeat (3) @(posedge clk);
  endtask

  task automatic test_random();
    logic [23:0] ra, rb, res;
    int lat;
    for (int i = 0; i < 1000; i++) begin
      ra = 24'($urandom);
      rb = 24'($urandom);
      if (i % 8 == 0) ra = {ra[23], {23{~ra[23]}}};
      run_op(ra, rb, res, lat);
      checks++;
      if (lat != 13 || res !== model(ra, rb)) begin
        errors++;
        $display("FAIL rand%0d a=%h b=%h got lat=%0d s=%h want lat=13 s=%h", i, ra, rb, lat, res, model(ra, rb));
      end
    end
  endtask

  initial begin
    test_reset();
    test_vectors();
    test_midop_reset();
    test_ignore_start();
    test_back_to_back();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
